// File: rtl/uart_fifo.sv
// uart_fifo -- UART with a TX FIFO, an RX FIFO and a small register bus.
//
// Ports
//   clk        single clock, all logic on the rising edge
//   reset      asynchronous active-low reset
//   read/write one-cycle bus strobes
//   address    register select (0 TX data, 1 RX data, 2 status, 3 config, 4 thresholds)
//   dataIn     write data
//   readValid  dataOut valid, two cycles after a read strobe
//   dataOut    registered read data
//   txIrq      TX level interrupt (registered)
//   rxIrq      RX level/error interrupt (registered)
//   rx         asynchronous serial input
//   tx         serial output, idles high
module uart_fifo #(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter logic [15:0] DEFAULT_CPB = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] dataIn,
  output logic        readValid,
  output logic [31:0] dataOut,
  output logic        txIrq,
  output logic        rxIrq,
  input  logic        rx,
  output logic        tx
);

  localparam int unsigned TXAW = $clog2(TX_DEPTH);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
  } txState_t;

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3, RX_STOP = 3'd4
  } rxState_t;

  // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
  function automatic logic parityBit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Registered bus copies
  logic        readR, writeR;
  logic [2:0]  addrR;
  logic [31:0] dataR;

  // Configuration and sticky status
  logic [15:0] cpb;
  logic [1:0]  parity;
  logic        twoStop, rxIre, txIre;
  logic [7:0]  rxThresh, txThresh;
  logic        txOverflow, parityErrS, frameErrS, rxOverrun;

  // FIFOs: pointers carry one extra wrap bit so full and empty differ
  logic [7:0]  txMem [TX_DEPTH];
  logic [9:0]  rxMem [RX_DEPTH];
  logic [TXAW:0] txWr, txRd;
  logic [RXAW:0] rxWr, rxRd;
  logic        txEmpty, txFull, rxEmpty, rxFull;
  logic [7:0]  txLevel8, rxLevel8;
  logic        txWrite, txAccept, txPop, rxPop, rxAccept;

  // TX engine
  txState_t    txState;
  logic [15:0] txCnt, txCpb;
  logic [7:0]  txShift;
  logic [2:0]  txBitIdx;
  logic        txParEn, txParBit, txTwo, txSecond;
  logic        txBitEnd, txStopDone;

  // RX engine
  rxState_t    rxState;
  logic        rxSync1, rxS, rxPrev;
  logic [15:0] rxCnt, rxCpb, rxHalf;
  logic [7:0]  rxShift;
  logic [2:0]  rxBitIdx;
  logic        rxParEn, rxParOdd, rxParErr;
  logic        rxPushR;
  logic [9:0]  rxPushData;

  logic [15:0] effCpb;
  logic        stsWrite;
  logic [7:0]  rxThEff;
  logic [31:0] rdData;

  assign effCpb   = (cpb < 16'd4) ? 16'd4 : cpb;
  assign stsWrite = writeR && (addrR == 3'd2);
  assign rxThEff  = (rxThresh == 8'd0) ? 8'd1 : rxThresh;

  assign txEmpty = (txWr == txRd);
  assign txFull  = (txWr[TXAW] != txRd[TXAW]) && (txWr[TXAW-1:0] == txRd[TXAW-1:0]);
  assign rxEmpty = (rxWr == rxRd);
  assign rxFull  = (rxWr[RXAW] != rxRd[RXAW]) && (rxWr[RXAW-1:0] == rxRd[RXAW-1:0]);

  assign txBitEnd   = (txCnt == txCpb);
  assign txStopDone = (txState == TX_STOP) && txBitEnd && (!txTwo || txSecond);
  // The engine pops whenever it is about to start a frame.
  assign txPop      = !txEmpty && ((txState == TX_IDLE) || txStopDone);
  assign txWrite    = writeR && (addrR == 3'd0);
  assign txAccept   = txWrite && (!txFull || txPop);
  assign rxPop      = readR && (addrR == 3'd1) && !rxEmpty;
  assign rxAccept   = rxPushR && (!rxFull || rxPop);
  assign rxHalf     = {1'b0, rxCpb[15:1]};

  // Zero-extend FIFO levels to the 8-bit status fields.
  always_comb begin
    txLevel8 = 8'd0;
    rxLevel8 = 8'd0;
    txLevel8[TXAW:0] = txWr - txRd;
    rxLevel8[RXAW:0] = rxWr - rxRd;
  end

  // Capture bus strobes, address and write data once before decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readR  <= 1'b0;
      writeR <= 1'b0;
      addrR  <= 3'd0;
      dataR  <= 32'd0;
    end else begin
      readR  <= read;
      writeR <= write;
      addrR  <= address;
      dataR  <= dataIn;
    end
  end

  // Read data multiplexer.
  always_comb begin
    rdData = 32'd0;
    case (addrR)
      3'd1: begin
        if (rxEmpty) begin
          rdData = 32'h8000_0000;
        end else begin
          rdData = {22'd0, rxMem[rxRd[RXAW-1:0]]};
        end
      end
      3'd2: rdData = {rxLevel8, txLevel8, 9'd0, txOverflow, parityErrS, frameErrS,
                      rxOverrun, (txEmpty && (txState == TX_IDLE)), !rxEmpty, !txFull};
      3'd3: rdData = {cpb, 10'd0, parity, twoStop, 1'b0, rxIre, txIre};
      3'd4: rdData = {16'd0, rxThresh, txThresh};
      default: rdData = 32'd0;
    endcase
  end

  // Registered read response; readValid follows the registered strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readValid <= 1'b0;
      dataOut   <= 32'd0;
    end else begin
      readValid <= readR;
      if (readR) begin
        dataOut <= rdData;
      end
    end
  end

  // Configuration and threshold registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpb      <= DEFAULT_CPB;
      parity   <= 2'b00;
      twoStop  <= 1'b0;
      rxIre    <= 1'b0;
      txIre    <= 1'b0;
      rxThresh <= 8'd1;
      txThresh <= 8'd0;
    end else if (writeR && (addrR == 3'd3)) begin
      cpb     <= dataR[31:16];
      parity  <= dataR[5:4];
      twoStop <= dataR[3];
      rxIre   <= dataR[1];
      txIre   <= dataR[0];
    end else if (writeR && (addrR == 3'd4)) begin
      rxThresh <= dataR[15:8];
      txThresh <= dataR[7:0];
    end
  end

  // Sticky error bits; a new event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txOverflow <= 1'b0;
      parityErrS <= 1'b0;
      frameErrS  <= 1'b0;
      rxOverrun  <= 1'b0;
    end else begin
      txOverflow <= (txWrite && txFull && !txPop) || (txOverflow && !(stsWrite && dataR[6]));
      parityErrS <= (rxPushR && rxPushData[9])   || (parityErrS && !(stsWrite && dataR[5]));
      frameErrS  <= (rxPushR && rxPushData[8])   || (frameErrS  && !(stsWrite && dataR[4]));
      rxOverrun  <= (rxPushR && rxFull && !rxPop) || (rxOverrun && !(stsWrite && dataR[3]));
    end
  end

  // FIFO storage (no reset needed; validity is tracked by the pointers).
  always_ff @(posedge clk) begin
    if (txAccept) begin
      txMem[txWr[TXAW-1:0]] <= dataR[7:0];
    end
    if (rxAccept) begin
      rxMem[rxWr[RXAW-1:0]] <= rxPushData;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txWr <= '0;
      txRd <= '0;
      rxWr <= '0;
      rxRd <= '0;
    end else begin
      if (txAccept) txWr <= txWr + 1'b1;
      if (txPop)    txRd <= txRd + 1'b1;
      if (rxAccept) rxWr <= rxWr + 1'b1;
      if (rxPop)    rxRd <= rxRd + 1'b1;
    end
  end

  // TX engine; frame settings are latched when a byte is popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txState  <= TX_IDLE;
      txCnt    <= 16'd1;
      txCpb    <= 16'd4;
      txShift  <= 8'd0;
      txBitIdx <= 3'd0;
      txParEn  <= 1'b0;
      txParBit <= 1'b0;
      txTwo    <= 1'b0;
      txSecond <= 1'b0;
      tx       <= 1'b1;
    end else begin
      case (txState)
        TX_IDLE: tx <= 1'b1;
        TX_START: begin
          if (txBitEnd) begin
            txCnt    <= 16'd1;
            txBitIdx <= 3'd0;
            tx       <= txShift[0];
            txState  <= TX_DATA;
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (txBitEnd) begin
            txCnt <= 16'd1;
            if (txBitIdx == 3'd7) begin
              txSecond <= 1'b0;
              if (txParEn) begin
                tx      <= txParBit;
                txState <= TX_PARITY;
              end else begin
                tx      <= 1'b1;
                txState <= TX_STOP;
              end
            end else begin
              txBitIdx <= txBitIdx + 3'd1;
              tx       <= txShift[txBitIdx + 3'd1];
            end
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        TX_PARITY: begin
          if (txBitEnd) begin
            txCnt   <= 16'd1;
            tx      <= 1'b1;
            txState <= TX_STOP;
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (txBitEnd) begin
            txCnt <= 16'd1;
            if (txTwo && !txSecond) begin
              txSecond <= 1'b1;
            end else begin
              tx      <= 1'b1;
              txState <= TX_IDLE;
            end
          end else begin
            txCnt <= txCnt + 16'd1;
          end
        end
        default: begin
          tx      <= 1'b1;
          txState <= TX_IDLE;
        end
      endcase
      // Starting a new frame overrides whatever the state above decided.
      if (txPop) begin
        txShift  <= txMem[txRd[TXAW-1:0]];
        txCpb    <= effCpb;
        txParEn  <= (parity == 2'b01) || (parity == 2'b10);
        txParBit <= parityBit(txMem[txRd[TXAW-1:0]], parity == 2'b10);
        txTwo    <= twoStop;
        txCnt    <= 16'd1;
        tx       <= 1'b0;
        txState  <= TX_START;
      end
    end
  end

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxSync1 <= 1'b1;
      rxS     <= 1'b1;
      rxPrev  <= 1'b1;
    end else begin
      rxSync1 <= rx;
      rxS     <= rxSync1;
      rxPrev  <= rxS;
    end
  end

  // RX engine; counts from the detected edge and samples each bit mid-way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxState    <= RX_IDLE;
      rxCnt      <= 16'd1;
      rxCpb      <= 16'd4;
      rxShift    <= 8'd0;
      rxBitIdx   <= 3'd0;
      rxParEn    <= 1'b0;
      rxParOdd   <= 1'b0;
      rxParErr   <= 1'b0;
      rxPushR    <= 1'b0;
      rxPushData <= 10'd0;
    end else begin
      rxPushR <= 1'b0;
      case (rxState)
        RX_IDLE: begin
          if (rxPrev && !rxS) begin
            rxCpb    <= effCpb;
            rxParEn  <= (parity == 2'b01) || (parity == 2'b10);
            rxParOdd <= (parity == 2'b10);
            rxParErr <= 1'b0;
            rxCnt    <= 16'd1;
            rxState  <= RX_START;
          end
        end
        RX_START: begin
          if (rxCnt == rxHalf) begin
            rxCnt    <= 16'd1;
            rxBitIdx <= 3'd0;
            // Line back high at mid-start: treat as a glitch.
            rxState  <= rxS ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rxCnt == rxCpb) begin
            rxCnt   <= 16'd1;
            rxShift <= {rxS, rxShift[7:1]};
            if (rxBitIdx == 3'd7) begin
              rxState <= rxParEn ? RX_PARITY : RX_STOP;
            end else begin
              rxBitIdx <= rxBitIdx + 3'd1;
            end
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        RX_PARITY: begin
          if (rxCnt == rxCpb) begin
            rxCnt    <= 16'd1;
            rxParErr <= (rxS != parityBit(rxShift, rxParOdd));
            rxState  <= RX_STOP;
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rxCnt == rxCpb) begin
            rxCnt      <= 16'd1;
            rxPushR    <= 1'b1;
            rxPushData <= {rxParErr && rxParEn, !rxS, rxShift};
            rxState    <= RX_IDLE;
          end else begin
            rxCnt <= rxCnt + 16'd1;
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  // Registered level interrupts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txIrq <= 1'b0;
      rxIrq <= 1'b0;
    end else begin
      txIrq <= txIre && (txLevel8 <= txThresh);
      rxIrq <= rxIre && ((rxLevel8 >= rxThEff) || rxOverrun || frameErrS || parityErrS);
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo -- directed/randomized bench for uart_fifo with a frame-level model.
module tb_uart_fifo;

  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [31:0] dataIn = 32'd0;
  logic        readValid, txIrq, rxIrq, tx;
  logic [31:0] dataOut;
  logic        rxDrive = 1'b1;
  logic        loopMode = 1'b0;
  logic        rxLine;

  int checks = 0;
  int passed = 0;

  assign rxLine = loopMode ? tx : rxDrive;

  uart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DEFAULT_CPB(16'd434)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .dataIn(dataIn), .readValid(readValid), .dataOut(dataOut),
    .txIrq(txIrq), .rxIrq(rxIrq), .rx(rxLine), .tx(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    address = a;
    dataIn  = d;
    write   = 1'b1;
    tick();
    write   = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    tick();
    check("readValid", {63'd0, readValid}, 64'd1);
    d = dataOut;
  endtask

  // Serial frame as a bit list: start, 8 data LSB first, optional parity, stop bit(s).
  function automatic int frameBits(input logic [7:0] b, input int pm, input bit two,
                                   output logic [11:0] bits);
    int n;
    int ones;
    bits = 12'd0;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    n = 9;
    if (pm == 1) begin
      bits[n] = ((ones % 2) == 1);
      n++;
    end else if (pm == 2) begin
      bits[n] = ((ones % 2) == 0);
      n++;
    end
    bits[n] = 1'b1;
    n++;
    if (two) begin
      bits[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  // Expected per-clock tx waveform: each frame bit held for cpb clocks.
  function automatic logic [63:0] expWave(input logic [11:0] bits, input int n, input int cpb);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < n * cpb; i++) w[i] = bits[i / cpb];
    return w;
  endfunction

  task automatic captureTx(input int len, output logic [63:0] w, output bit to);
    int t;
    w  = 64'd0;
    to = 1'b0;
    t  = 0;
    while (tx !== 1'b0 && t < 200) begin
      tick();
      t++;
    end
    if (tx !== 1'b0) to = 1'b1;
    for (int i = 0; i < len; i++) begin
      w[i] = tx;
      tick();
    end
  endtask

  task automatic sendRx(input logic [7:0] b, input int pm, input bit flip,
                        input logic stopVal, input int cpb);
    logic [11:0] bits;
    int n;
    n = frameBits(b, pm, 1'b0, bits);
    if (flip) bits[9] = ~bits[9];
    bits[n-1] = stopVal;
    for (int i = 0; i < n; i++) begin
      rxDrive = bits[i];
      repeat (cpb) tick();
    end
    rxDrive = 1'b1;
    repeat (2 * cpb) tick();
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] w;
    logic [11:0] bits;
    logic [7:0]  b;
    logic [1:0]  pmL;
    logic [7:0]  expQ[$];
    int          n;
    int          pm;
    int          t;
    bit          two;
    bit          to;

    // Reset state
    repeat (3) tick();
    check("rst_tx", {63'd0, tx}, 64'd1);
    check("rst_txIrq", {63'd0, txIrq}, 64'd0);
    check("rst_rxIrq", {63'd0, rxIrq}, 64'd0);
    check("rst_readValid", {63'd0, readValid}, 64'd0);
    check("rst_dataOut", {32'd0, dataOut}, 64'd0);
    reset = 1'b1;
    repeat (2) tick();
    busRead(3'd2, d); check("rst_status", {32'd0, d}, 64'h0000_0005);
    busRead(3'd3, d); check("rst_config", {32'd0, d}, 64'h01B2_0000);
    busRead(3'd4, d); check("rst_thresh", {32'd0, d}, 64'h0000_0100);
    busWrite(3'd6, 32'hFFFF_FFFF);
    busRead(3'd6, d); check("unmapped", {32'd0, d}, 64'd0);
    busRead(3'd0, d); check("txDataRead", {32'd0, d}, 64'd0);

    // Known frame: 0xA5, 4 clocks per bit, no parity
    busWrite(3'd3, 32'h0004_0000);
    busWrite(3'd0, 32'h0000_00A5);
    n = frameBits(8'hA5, 0, 1'b0, bits);
    captureTx(n * 4, w, to);
    check("a5_start", {63'd0, to}, 64'd0);
    check("a5_wave", w, expWave(bits, n, 4));
    repeat (4) tick();
    busRead(3'd2, d); check("a5_status", {32'd0, d}, 64'h0000_0005);

    // Randomized loopback frames with random parity and stop settings
    loopMode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b   = 8'($urandom_range(0, 255));
      pm  = int'($urandom_range(0, 3));
      two = 1'($urandom_range(0, 1));
      pmL = 2'(pm);
      busWrite(3'd3, {16'd4, 10'd0, pmL, two, 3'd0});
      busWrite(3'd0, {24'd0, b});
      n = frameBits(b, pm, two, bits);
      captureTx(n * 4, w, to);
      check("loop_start", {63'd0, to}, 64'd0);
      check("loop_wave", w, expWave(bits, n, 4));
      repeat (4) tick();
      busRead(3'd1, d);
      check("loop_rx", {32'd0, d}, {56'd0, b});
    end

    // Even parity loopback, then an injected parity error and a framing error
    busWrite(3'd3, 32'h0004_0010);
    busWrite(3'd0, 32'h0000_003C);
    n = frameBits(8'h3C, 1, 1'b0, bits);
    captureTx(n * 4, w, to);
    check("even_wave", w, expWave(bits, n, 4));
    repeat (4) tick();
    busRead(3'd1, d); check("even_rx", {32'd0, d}, 64'h0000_003C);
    loopMode = 1'b0;
    sendRx(8'h3C, 1, 1'b1, 1'b1, 4);
    busRead(3'd1, d); check("parerr_rx", {32'd0, d}, 64'h0000_023C);
    busRead(3'd2, d); check("parerr_status", {32'd0, d}, 64'h0000_0025);
    busWrite(3'd2, 32'h0000_0020);
    busRead(3'd2, d); check("parerr_w1c", {32'd0, d}, 64'h0000_0005);
    b = 8'($urandom_range(0, 255));
    sendRx(b, 1, 1'b0, 1'b0, 4);
    busRead(3'd1, d); check("frmerr_rx", {32'd0, d}, {54'd0, 2'b01, b});
    busRead(3'd2, d); check("frmerr_status", {32'd0, d}, 64'h0000_0015);
    busWrite(3'd2, 32'h0000_0010);

    // RX overrun: RXD+1 frames without reading
    busWrite(3'd3, 32'h0004_0002);
    for (int k = 0; k < RXD + 1; k++) begin
      b = 8'($urandom_range(0, 255));
      if (k < RXD) expQ.push_back(b);
      sendRx(b, 0, 1'b0, 1'b1, 4);
    end
    busRead(3'd2, d); check("ovr_status", {32'd0, d}, 64'h1000_000F);
    check("ovr_rxIrq", {63'd0, rxIrq}, 64'd1);
    while (expQ.size() > 0) begin
      busRead(3'd1, d);
      check("ovr_order", {32'd0, d}, {56'd0, expQ.pop_front()});
    end

    // Read of an empty RX FIFO
    busRead(3'd1, d); check("empty_rx", {32'd0, d}, 64'h8000_0000);
    tick();
    check("empty_validPulse", {63'd0, readValid}, 64'd0);
    busRead(3'd2, d); check("empty_status", {32'd0, d}, 64'h0000_000D);
    busWrite(3'd2, 32'h0000_0008);
    busRead(3'd2, d); check("ovr_w1c", {32'd0, d}, 64'h0000_0005);
    check("ovr_rxIrqClear", {63'd0, rxIrq}, 64'd0);

    // Short low glitch on rx must not produce a frame
    busWrite(3'd3, 32'h0010_0000);
    rxDrive = 1'b0;
    repeat (3) tick();
    rxDrive = 1'b1;
    repeat (250) tick();
    busRead(3'd2, d); check("glitch_status", {32'd0, d}, 64'h0000_0005);

    // TX overflow: TXD+2 back-to-back writes starting from an idle engine
    busWrite(3'd3, 32'h0004_0001);
    repeat (2) tick();
    check("txIrq_idle", {63'd0, txIrq}, 64'd1);
    for (int k = 0; k < TXD + 2; k++) begin
      address = 3'd0;
      dataIn  = 32'(k);
      write   = 1'b1;
      tick();
    end
    write = 1'b0;
    tick();
    busRead(3'd2, d); check("txovf_status", {32'd0, d}, 64'h0010_0040);
    check("txIrq_full", {63'd0, txIrq}, 64'd0);

    // Reset in the middle of a frame
    t = 0;
    while (tx !== 1'b0 && t < 100) begin
      tick();
      t++;
    end
    check("midframe_txLow", {63'd0, tx}, 64'd0);
    reset = 1'b0;
    #1;
    check("midreset_tx", {63'd0, tx}, 64'd1);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    busRead(3'd2, d); check("postrst_status", {32'd0, d}, 64'h0000_0005);
    busRead(3'd3, d); check("postrst_config", {32'd0, d}, 64'h01B2_0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
